// File: rtl/approx_mul_pkg.sv
// ============================================================================
// Module : approx_mul_pkg
// Brief  : Shared types and defaults for the approximate multiplier and its
//          error-metric accumulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_W         = 8;
  localparam int DEF_N_SAMPLES = 10000;
  localparam int DEF_CNT_W     = 14;
  localparam int DEF_SUM_W     = 32;

endpackage

`default_nettype wire

// File: rtl/err_dist_calc.sv
// ============================================================================
// Module : err_dist_calc
// Brief  : Combinational exact product, signed error distance and |ED|.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module err_dist_calc #(
  parameter int W = 8
) (
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [2*W-1:0]      apprx,
  output logic [2*W-1:0]      exact,
  output logic signed [2*W:0] ed,
  output logic [2*W-1:0]      ed_abs
);

  assign exact = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign ed    = $signed({1'b0, exact}) - $signed({1'b0, apprx});

  // |ed| never exceeds 2**(2W)-1, so the low 2W bits of the negation suffice
  assign ed_abs = ed[2*W] ? (~ed[2*W-1:0] + 1'b1) : ed[2*W-1:0];

endmodule

`default_nettype wire

// File: rtl/approx_err_accum.sv
// ============================================================================
// Module : approx_err_accum
// Brief  : Two-stage pipe plus accumulators for ER/MED/MRED/MNED statistics.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module approx_err_accum
  import approx_mul_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SUM_W     = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   apprx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] nz_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [SUM_W-1:0] sum_ed_abs,
  output logic [2*W-1:0]   max_ed
);

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [2*W-1:0]    apprx_q, apprx_d;
  logic              v1_q, v1_d;

  logic [2*W-1:0]    exact_w, ed_abs_w;
  logic signed [2*W:0] ed_w;

  logic [2*W-1:0]    exact_q, exact_d, ed_abs_q, ed_abs_d;
  logic signed [2*W:0] ed_q, ed_d;
  logic              v2_q, v2_d;

  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d, nz_cnt_q, nz_cnt_d;
  logic [SUM_W-1:0]  sum_ed_q, sum_ed_d, sum_ed_abs_q, sum_ed_abs_d;
  logic [2*W-1:0]    max_ed_q, max_ed_d;

  logic              accept;

  assign accept = in_valid & in_ready_q;

  err_dist_calc #(.W(W)) u_calc (
    .a      (a_q),
    .b      (b_q),
    .apprx  (apprx_q),
    .exact  (exact_w),
    .ed     (ed_w),
    .ed_abs (ed_abs_w)
  );

  always_comb begin
    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    apprx_d      = apprx_q;
    v1_d         = accept;
    exact_d      = exact_q;
    ed_d         = ed_q;
    ed_abs_d     = ed_abs_q;
    v2_d         = v1_q;
    err_cnt_d    = err_cnt_q;
    nz_cnt_d     = nz_cnt_q;
    sum_ed_d     = sum_ed_q;
    sum_ed_abs_d = sum_ed_abs_q;
    max_ed_d     = max_ed_q;

    if (accept) begin
      a_d     = a;
      b_d     = b;
      apprx_d = apprx;
    end

    if (v1_q) begin
      exact_d  = exact_w;
      ed_d     = ed_w;
      ed_abs_d = ed_abs_w;
    end

    if (v2_q) begin
      err_cnt_d    = err_cnt_q + {{(CNT_W-1){1'b0}}, (ed_abs_q != '0)};
      nz_cnt_d     = nz_cnt_q + {{(CNT_W-1){1'b0}}, (exact_q != '0)};
      sum_ed_d     = sum_ed_q + {{(SUM_W-2*W-1){ed_q[2*W]}}, ed_q};
      sum_ed_abs_d = sum_ed_abs_q + {{(SUM_W-2*W){1'b0}}, ed_abs_q};
      if (ed_abs_q > max_ed_q) max_ed_d = ed_abs_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          acc_cnt_d    = '0;
          err_cnt_d    = '0;
          nz_cnt_d     = '0;
          sum_ed_d     = '0;
          sum_ed_abs_d = '0;
          max_ed_d     = '0;
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (acc_cnt_q == N_LAST - CNT_W'(1)) state_d = DRAIN;
        end
      end
      // Exit only once both stages are empty so the last accumulate has landed
      DRAIN:   if (!v1_q && !v2_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == RUN) && (acc_cnt_d < N_LAST);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_cnt_q    <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      apprx_q      <= '0;
      v1_q         <= 1'b0;
      exact_q      <= '0;
      ed_q         <= '0;
      ed_abs_q     <= '0;
      v2_q         <= 1'b0;
      err_cnt_q    <= '0;
      nz_cnt_q     <= '0;
      sum_ed_q     <= '0;
      sum_ed_abs_q <= '0;
      max_ed_q     <= '0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      a_q          <= a_d;
      b_q          <= b_d;
      apprx_q      <= apprx_d;
      v1_q         <= v1_d;
      exact_q      <= exact_d;
      ed_q         <= ed_d;
      ed_abs_q     <= ed_abs_d;
      v2_q         <= v2_d;
      err_cnt_q    <= err_cnt_d;
      nz_cnt_q     <= nz_cnt_d;
      sum_ed_q     <= sum_ed_d;
      sum_ed_abs_q <= sum_ed_abs_d;
      max_ed_q     <= max_ed_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_cnt    = err_cnt_q;
  assign nz_cnt     = nz_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign sum_ed_abs = sum_ed_abs_q;
  assign max_ed     = max_ed_q;

endmodule

`default_nettype wire

// File: tb/tb_approx_err_accum.sv
// ============================================================================
// Module : tb_approx_err_accum
// Brief  : Directed checks of approx_err_accum over several campaign sizes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_approx_err_accum;

  function automatic int n_of(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      2:       return 2;
      3:       return 5;
      default: return 10000;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  start = '0;
  logic [4:0]  in_valid = '0;
  logic [4:0]  in_ready, busy, done;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] apprx = '0;
  logic [13:0] err_cnt [5];
  logic [13:0] nz_cnt [5];
  logic [31:0] sum_ed [5];
  logic [31:0] sum_ed_abs [5];
  logic [15:0] max_ed [5];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  generate
    for (genvar i = 0; i < 5; i++) begin : g_dut
      approx_err_accum #(
        .W(8), .N_SAMPLES(n_of(i)), .CNT_W(14), .SUM_W(32)
      ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start[i]),
        .in_valid   (in_valid[i]),
        .in_ready   (in_ready[i]),
        .a          (a),
        .b          (b),
        .apprx      (apprx),
        .busy       (busy[i]),
        .done       (done[i]),
        .err_cnt    (err_cnt[i]),
        .nz_cnt     (nz_cnt[i]),
        .sum_ed     (sum_ed[i]),
        .sum_ed_abs (sum_ed_abs[i]),
        .max_ed     (max_ed[i])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int idx);
    start[idx] = 1'b1;
    tick();
    start[idx] = 1'b0;
  endtask

  task automatic send(input int idx, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] p);
    a = x;
    b = y;
    apprx = p;
    in_valid[idx] = 1'b1;
    chk("in_ready_at_send", {31'd0, in_ready[idx]}, 32'd1);
    tick();
    in_valid[idx] = 1'b0;
  endtask

  // k counts edges after the last accept edge
  task automatic wait_done(input int idx, output int first_k, output int pulses);
    first_k = -1;
    pulses  = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done[idx]) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
  endtask

  task automatic chk_stats(input int idx, input logic [31:0] e_err, input logic [31:0] e_nz,
                           input logic [31:0] e_sum, input logic [31:0] e_abs,
                           input logic [31:0] e_max);
    chk("err_cnt",    {18'd0, err_cnt[idx]}, e_err);
    chk("nz_cnt",     {18'd0, nz_cnt[idx]},  e_nz);
    chk("sum_ed",     sum_ed[idx],           e_sum);
    chk("sum_ed_abs", sum_ed_abs[idx],       e_abs);
    chk("max_ed",     {16'd0, max_ed[idx]},  e_max);
  endtask

  // Reference approximate core: exact, truncated, padded or bit-flipped product
  function automatic logic [15:0] core_model(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = {8'd0, x} * {8'd0, y};
    case (x[1:0] ^ y[1:0])
      2'd0:    return p;
      2'd1:    return p & 16'hFFF8;
      2'd2:    return p | 16'h0007;
      default: return p ^ 16'h0100;
    endcase
  endfunction

  initial begin
    int first_k, pulses, accepts, last_i, done_i, done_cnt, not_ready;
    int m_err, m_nz, m_sum, m_abs, m_max, e;
    logic [7:0]  x, y;
    logic [15:0] p, ap;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {27'd0, in_ready}, 32'd0);
    chk("rst_busy",     {27'd0, busy},     32'd0);
    chk("rst_done",     {27'd0, done},     32'd0);
    chk_stats(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // 1) exact core, N=4
    pulse_start(0);
    chk("busy_run", {31'd0, busy[0]}, 32'd1);
    send(0, 8'd3,   8'd5,   16'd15);
    send(0, 8'd0,   8'd9,   16'd0);
    send(0, 8'd255, 8'd255, 16'd65025);
    send(0, 8'd2,   8'd2,   16'd4);
    wait_done(0, first_k, pulses);
    chk("t1_done_pulses", pulses, 32'd1);
    chk("t1_done_lat",    first_k, 32'd3);
    chk_stats(0, 0, 3, 0, 0, 0);
    chk("t1_busy_idle", {31'd0, busy[0]}, 32'd0);

    // Samples offered in IDLE are dropped
    a = 8'd1; b = 8'd1; apprx = 16'd0;
    in_valid[0] = 1'b1;
    tick();
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    chk_stats(0, 0, 3, 0, 0, 0);

    // 2) mixed-sign errors, N=3
    pulse_start(1);
    send(1, 8'd10, 8'd10, 16'd96);
    send(1, 8'd10, 8'd10, 16'd104);
    send(1, 8'd4,  8'd4,  16'd0);
    wait_done(1, first_k, pulses);
    chk("t2_done_pulses", pulses, 32'd1);
    chk_stats(1, 3, 3, 16, 24, 16);

    // 3) maximal error twice, N=2
    pulse_start(2);
    send(2, 8'd255, 8'd255, 16'd0);
    send(2, 8'd255, 8'd255, 16'd0);
    wait_done(2, first_k, pulses);
    chk("t3_done_pulses", pulses, 32'd1);
    chk_stats(2, 2, 2, 130050, 130050, 65025);

    // 4) in_valid held 20 cycles, N=5, start during RUN ignored; apprx = exact+1
    pulse_start(3);
    accepts = 0; last_i = -1; done_i = -1; done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i + 1);
      b = 8'd3;
      apprx = 16'((i + 1) * 3 + 1);
      in_valid[3] = 1'b1;
      start[3] = (i == 2);
      if (in_ready[3]) begin
        accepts++;
        last_i = i;
      end
      if (done[3]) begin
        done_cnt++;
        if (done_i < 0) done_i = i;
      end
      tick();
    end
    in_valid[3] = 1'b0;
    start[3] = 1'b0;
    chk("t4_accepts", accepts, 32'd5);
    chk("t4_ready_after", {31'd0, in_ready[3]}, 32'd0);
    chk("t4_done_pulses", done_cnt, 32'd1);
    // ready seen at iteration i means accept on the next edge; done 3 edges later
    chk("t4_done_lat", done_i - last_i, 32'd4);
    chk_stats(3, 5, 5, 32'hFFFF_FFFB, 5, 1);

    // 5) reset mid-RUN after two samples
    pulse_start(3);
    send(3, 8'd3, 8'd3, 16'd8);
    send(3, 8'd3, 8'd3, 16'd8);
    repeat (3) tick();
    chk("t5_pre_rst_sum", sum_ed[3], 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy",  {31'd0, busy[3]},     32'd0);
    chk("t5_rst_ready", {31'd0, in_ready[3]}, 32'd0);
    chk_stats(3, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(3);
    for (int i = 0; i < 5; i++) send(3, 8'd3, 8'd3, 16'd8);
    wait_done(3, first_k, pulses);
    chk("t5_done_pulses", pulses, 32'd1);
    chk_stats(3, 5, 5, 5, 5, 1);

    // 6) 10000 random samples against the core model
    m_err = 0; m_nz = 0; m_sum = 0; m_abs = 0; m_max = 0; not_ready = 0;
    pulse_start(4);
    for (int i = 0; i < 10000; i++) begin
      x = (i % 37 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      p = {8'd0, x} * {8'd0, y};
      ap = core_model(x, y);
      e = int'(p) - int'(ap);
      if (e != 0) m_err++;
      if (p != 16'd0) m_nz++;
      m_sum += e;
      m_abs += (e < 0) ? -e : e;
      if (((e < 0) ? -e : e) > m_max) m_max = (e < 0) ? -e : e;
      a = x;
      b = y;
      apprx = ap;
      in_valid[4] = 1'b1;
      if (!in_ready[4]) not_ready++;
      tick();
    end
    in_valid[4] = 1'b0;
    chk("t6_not_ready", not_ready, 32'd0);
    wait_done(4, first_k, pulses);
    chk("t6_done_pulses", pulses, 32'd1);
    chk_stats(4, m_err, m_nz, m_sum, m_abs, m_max);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
